// File: rtl/rr_sel_arbiter_if.sv
// Request/data bus between four requesters, the round-robin arbiter and the
// downstream consumer of the pipelined mux output.
interface rr_sel_arbiter_if;
    logic [3:0] req;
    logic [3:0] d;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic       y;
    logic       y_valid;

    modport master (
        output req,
        output d,
        input  sel,
        input  gnt,
        input  gnt_valid,
        input  y,
        input  y_valid
    );

    modport slave (
        input  req,
        input  d,
        output sel,
        output gnt,
        output gnt_valid,
        output y,
        output y_valid
    );
endinterface

// File: rtl/rr_sel_arbiter.sv
// Four-way round-robin arbiter driving a 4:1 mux select, with a registered
// copy of the selected data bit and an optional hold timeout for fairness.
module rr_sel_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_sel_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [1:0]       sel_q;
    logic [3:0]       gnt_q;
    logic             gv_q;
    logic             y_q;
    logic             yv_q;
    logic [CNT_W-1:0] cnt;

    logic [1:0] rot_ptr;
    logic [3:0] others;
    logic       released;
    logic       timed_out;
    logic [2:0] idle_pick;
    logic [2:0] grant_pick;

    // Returns {found, index} of the first set bit of r scanning upward from p with wrap.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                pick = {1'b1, idx};
            end
        end
    endfunction

    always_comb begin
        rot_ptr    = sel_q + 2'd1;
        others     = bus.req & ~gnt_q;
        released   = ~bus.req[sel_q];
        timed_out  = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT)) && (others != 4'b0000);
        idle_pick  = pick(bus.req, ptr);
        grant_pick = pick(others, rot_ptr);
    end

    // A release and a timeout both rotate past the current grantee; on release its
    // request bit is already low, so excluding it from the scan changes nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel_q <= 2'd0;
            gnt_q <= 4'b0000;
            gv_q  <= 1'b0;
            y_q   <= 1'b0;
            yv_q  <= 1'b0;
            cnt   <= '0;
        end else begin
            y_q  <= gv_q ? bus.d[sel_q] : 1'b0;
            yv_q <= gv_q;
            case (state)
                IDLE: begin
                    if (idle_pick[2]) begin
                        state <= GRANT;
                        sel_q <= idle_pick[1:0];
                        gnt_q <= 4'b0001 << idle_pick[1:0];
                        gv_q  <= 1'b1;
                        cnt   <= CNT_W'(1);
                    end
                end
                GRANT: begin
                    if (released || timed_out) begin
                        ptr <= rot_ptr;
                        if (grant_pick[2]) begin
                            sel_q <= grant_pick[1:0];
                            gnt_q <= 4'b0001 << grant_pick[1:0];
                            gv_q  <= 1'b1;
                            cnt   <= CNT_W'(1);
                        end else begin
                            state <= IDLE;
                            gnt_q <= 4'b0000;
                            gv_q  <= 1'b0;
                            cnt   <= '0;
                        end
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gv_q;
    assign bus.y         = y_q;
    assign bus.y_valid   = yv_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench for rr_sel_arbiter: directed vector table, hand-written
// multi-cycle sequences and sticky random requests against a reference model.
module tb_rr_sel_arbiter;

    localparam int TO    = 4;
    localparam int CNTW  = 4;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic clk;
    logic rst_n;

    rr_sel_arbiter_if bus();

    rr_sel_arbiter #(
        .TIMEOUT(TO),
        .CNT_W  (CNTW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: owner is the granted requester or -1 when idle.
    int   mPtr;
    int   mOwner;
    int   mCnt;
    int   mSel;
    logic mY;
    logic mYv;

    typedef struct {
        logic [3:0] req;
        logic [3:0] d;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       gv;
        logic       y;
        logic       yv;
    } vec_t;

    vec_t vecs[7];

    function automatic int firstReq(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic resetModel();
        mPtr   = 0;
        mOwner = -1;
        mCnt   = 0;
        mSel   = 0;
        mY     = 1'b0;
        mYv    = 1'b0;
    endtask

    task automatic modelStep(input logic [3:0] r, input logic [3:0] dd);
        int w;
        logic [3:0] rest;
        mY  = (mOwner >= 0) ? dd[mOwner] : 1'b0;
        mYv = (mOwner >= 0);
        if (mOwner < 0) begin
            w = firstReq(r, mPtr);
            if (w >= 0) begin
                mOwner = w;
                mSel   = w;
                mCnt   = 1;
            end
        end else begin
            rest = r;
            rest[mOwner] = 1'b0;
            if (!r[mOwner] || (mCnt == TO && rest != 4'b0000)) begin
                mPtr = (mOwner + 1) % 4;
                w = firstReq(rest, mPtr);
                if (w >= 0) begin
                    mOwner = w;
                    mSel   = w;
                    mCnt   = 1;
                end else begin
                    mOwner = -1;
                    mCnt   = 0;
                end
            end else begin
                mCnt = (mCnt + 1 > CMAX) ? CMAX : mCnt + 1;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] eGnt, input logic [1:0] eSel,
                               input logic eGv, input logic eY, input logic eYv);
        checks++;
        if ({bus.sel, bus.gnt, bus.gnt_valid, bus.y, bus.y_valid} !== {eSel, eGnt, eGv, eY, eYv}) begin
            fails++;
            $display("[TB] FAIL %s: got sel=%0d gnt=%b gv=%b y=%b yv=%b, expected sel=%0d gnt=%b gv=%b y=%b yv=%b",
                     tag, bus.sel, bus.gnt, bus.gnt_valid, bus.y, bus.y_valid, eSel, eGnt, eGv, eY, eYv);
        end
    endtask

    task automatic checkModel(input string tag);
        logic [3:0] eg;
        eg = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
        checkOutput(tag, eg, 2'(mSel), mOwner >= 0, mY, mYv);
    endtask

    // Drive inputs, advance the model over the same edge, then compare 1 time unit later.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] dd, input string tag);
        bus.req = r;
        bus.d   = dd;
        modelStep(r, dd);
        @(posedge clk);
        #1;
        checkModel(tag);
    endtask

    task automatic resetDut();
        bus.req = 4'b0000;
        bus.d   = 4'b0000;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
    endtask

    initial begin
        logic [3:0] r;
        int g;

        rst_n   = 1'b0;
        bus.req = 4'b0000;
        bus.d   = 4'b0000;
        resetModel();

        vecs[0] = '{4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0};

        resetDut();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].req, vecs[i].d, $sformatf("table_model[%0d]", i));
            checkOutput($sformatf("table[%0d]", i), vecs[i].gnt, vecs[i].sel, vecs[i].gv, vecs[i].y, vecs[i].yv);
        end

        // Round robin: everyone requests, each grantee drops out after 3 grant cycles.
        resetDut();
        applyStimulus(4'b1111, 4'b0000, "rr_model");
        checkOutput("rr_first", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            g = i % 4;
            for (int c = 1; c < 3; c++) begin
                applyStimulus(4'b1111, 4'b0000, "rr_model");
                checkOutput($sformatf("rr_hold_g%0d", g), 4'(1 << g), 2'(g), 1'b1, 1'b0, 1'b1);
            end
            if (i < 4) begin
                r = 4'b1111;
                r[g] = 1'b0;
                applyStimulus(r, 4'b0000, "rr_model");
                checkOutput($sformatf("rr_next_g%0d", (g + 1) % 4), 4'(1 << ((g + 1) % 4)),
                            2'((g + 1) % 4), 1'b1, 1'b0, 1'b1);
            end
        end

        // Timeout rotation between two persistent requesters, then a lone requester.
        resetDut();
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(4'b0011, 4'b0000, "timeout_model");
            checkOutput($sformatf("timeout_cycle%0d", k), (k >= 5 && k <= 8) ? 4'b0010 : 4'b0001,
                        (k >= 5 && k <= 8) ? 2'd1 : 2'd0, 1'b1, 1'b0, k > 1);
        end
        for (int k = 0; k < 22; k++) begin
            applyStimulus(4'b0001, 4'b0000, "lone_model");
            checkOutput($sformatf("lone_hold%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        end

        // Asynchronous reset asserted between edges in the middle of a grant.
        resetDut();
        applyStimulus(4'b0100, 4'b0100, "async_model");
        applyStimulus(4'b0100, 4'b0100, "async_model");
        checkOutput("async_pre", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_clear", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        bus.req = 4'b1111;
        @(posedge clk);
        #1;
        checkOutput("async_held", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
        applyStimulus(4'b1111, 4'b0100, "async_model");
        checkOutput("async_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

        // Pointer wrap from requester 3 back to 0.
        resetDut();
        applyStimulus(4'b1000, 4'b0000, "wrap_model");
        checkOutput("wrap_g3", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1001, 4'b0000, "wrap_model");
        applyStimulus(4'b0001, 4'b0000, "wrap_model");
        checkOutput("wrap_g0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);

        // Sticky random requests with random data.
        resetDut();
        r = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            applyStimulus(r, 4'($urandom), $sformatf("random[%0d]", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
- Four-requester round-robin arbiter that sits directly upstream of the 4-to-1 mux.
- Drives the mux select lines (sel) and a one-hot grant back to the requesters.
- Carries an internal registered copy of the selected data bit, so downstream logic sees a pipelined mux output with a valid flag.
- Enforces fairness via pointer rotation and an optional hold timeout.

Parameters:
- TIMEOUT, 15: maximum consecutive grant cycles before a forced rotation when another requester is waiting; 0 disables the timeout.
- CNT_W, 4: width of the hold-cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines; req[i] is held high until requester i is done.
- d  input  4  data bits d0..d3 (d[i] belongs to requester i).
- sel  output  2  mux select, equal to the index of the current grantee; registered.
- gnt  output  4  one-hot grant, or all-zero when idle; registered.
- gnt_valid  output  1  high when a grant is active; equals |gnt.
- y  output  1  registered d[sel] while a grant is active, else 0.
- y_valid  output  1  gnt_valid delayed by one cycle.

Behaviour:
- Reset (async, rst_n=0):
  - sel=2'b00, gnt=4'b0000, gnt_valid=0, y=0, y_valid=0.
  - Priority pointer ptr=0; hold counter=0; state=IDLE.
  - Takes effect immediately, mid-grant included. Outputs stay cleared until the first clk edge after rst_n rises.
- States: IDLE, GRANT.
- Arbitration function:
  - Scan req starting at index ptr upward, wrapping 3->0.
  - The first set bit wins; index w.
- IDLE:
  - If req!=0, register gnt=1<<w, sel=w, gnt_valid=1, counter=1, and go to GRANT.
  - Latency: request seen at edge N, grant visible after edge N+1 (one cycle).
  - If req==0, hold all outputs at idle values.
- GRANT, normal hold:
  - While req[sel]=1 and no timeout rotation applies, keep gnt/sel unchanged.
  - Counter increments and saturates at 2^CNT_W-1.
- GRANT, release (req[sel]=0 sampled):
  - Set ptr=(sel+1) mod 4 and arbitrate in the same cycle over the remaining req using the new ptr.
  - If a winner exists, the new grant is registered at the next edge, giving back-to-back grants with no idle gap; counter=1.
  - If no winner, gnt=0, gnt_valid=0, state=IDLE.
- GRANT, timeout rotation:
  - Applies when TIMEOUT!=0, counter==TIMEOUT, and (req & ~gnt)!=0.
  - Set ptr=(sel+1) mod 4, arbitrate excluding the current grantee, register the new grant at the next edge, counter=1.
  - If no other requester is waiting, the current grant continues indefinitely (counter saturates).
- Simultaneous release and timeout: treated as a release (same result).
- Invariants:
  - gnt is one-hot or zero.
  - sel is undefined-free: it holds its last value when idle.
  - gnt_valid==|gnt.
- Data path:
  - Each edge, y <= gnt_valid ? d[sel] : 0, and y_valid <= gnt_valid.
  - y reflects d sampled in the same cycle as the registered sel.
  - Total latency from req to y_valid is two cycles.
- Requests that drop before being granted are simply not selected; there is no request latching.

Test Plan:
- Reset then req=4'b0101, all held: gnt=4'b0001, sel=0 one cycle later. Drop req[0]: the next cycle gives gnt=4'b0100, sel=2 with no gap cycle.
- Round robin: req=4'b1111 with each grantee releasing after 3 cycles. The grant order is 0,1,2,3,0, and each grant lasts exactly 3 cycles.
- Timeout with TIMEOUT=4 and req=4'b0011 held high:
  - gnt=0001 for 4 cycles, then 0010 for 4 cycles, then 0001 again.
  - With req=4'b0001 alone, gnt=0001 persists for 20+ cycles.
- Data path: grant to requester 2 with d=4'b0100 then d=4'b0000. y goes to 1 then 0, each one cycle after the d change, and y_valid=1 for those cycles. When idle, y=0 and y_valid=0.
- Async reset mid-grant: with gnt=0100, drop rst_n between clock edges. gnt/sel/gnt_valid/y/y_valid clear immediately. After release with req=1111, the first grant goes to index 0 (ptr reset).
- Pointer wrap: after requester 3 releases with req=4'b1001 pending, the next grant is index 0, not 3.
